// File: rtl/arm_decode_stage.sv
// arm_decode_stage: registered ID stage of the 5-stage ARM pipeline.
// Decodes the IF/ID instruction into an ID/EX register handled with
// valid/ready, with a load-use interlock of LU_STALL bubbles, branch
// flush and EX back-pressure. stall_o is combinational so fetch holds
// in the very cycle a hazard or back-pressure is seen.
// Optional macro DECODE_PERF_CNT_EN adds saturating stall/bubble counters.
module arm_decode_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int LU_STALL = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  input  logic              ex_ld_valid_i,
  input  logic [REG_AW-1:0] ex_ld_rd_i,
  output logic              stall_o,
  output logic              id_valid_o,
  output logic [3:0]        opcode_o,
  output logic [REG_AW-1:0] rn_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rm_o,
  output logic [1:0]        alu_src_sel_o,
  output logic              reg_wr_en_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic              cpsr_en_o,
  output logic              branch_o,
  output logic              shifter_en_o,
  output logic [3:0]        cond_o,
  output logic [DATA_W-1:0] pc_plus4_o,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o,
`endif
  output logic [DATA_W-1:0] imm_o
);

  typedef enum logic [0:0] {RUN = 1'b0, INTERLOCK = 1'b1} state_t;

  state_t            state_r, nxt_state_s;
  logic [1:0]        cnt_r, nxt_cnt_s;
  logic              mem_s, dp_s, br_s, bl_s, use_rn_s, use_rm_s, haz_s;
  logic [3:0]        opcode_s;
  logic [REG_AW-1:0] rn_s, rd_s, rm_s;
  logic [1:0]        sel_s;
  logic              reg_wr_s, mem_rd_s, mem_wr_s, cpsr_s, shift_s;
  logic [DATA_W-1:0] imm_s;
  logic              load_en_s, nxt_valid_s, stall_s;

  // Instruction decode and load-use hazard detection.
  always_comb begin
    mem_s = (instr_i[27:26] == 2'b01);
    dp_s  = (instr_i[27:26] == 2'b00);
    br_s  = (instr_i[27:25] == 3'b101);
    bl_s  = br_s & instr_i[24];
    if (bl_s) begin
      opcode_s = 4'b1101;
    end else if (mem_s) begin
      opcode_s = instr_i[23] ? 4'b0100 : 4'b0010;
    end else begin
      opcode_s = instr_i[24:21];
    end
    rn_s = bl_s ? REG_AW'(4'd0)  : REG_AW'(instr_i[19:16]);
    rd_s = bl_s ? REG_AW'(4'd14) : REG_AW'(instr_i[15:12]);
    rm_s = REG_AW'(instr_i[3:0]);
    if (mem_s) begin
      sel_s = 2'b00;
    end else if (br_s) begin
      sel_s = 2'b01;
    end else begin
      sel_s = 2'b10;
    end
    mem_rd_s = mem_s & instr_i[20];
    mem_wr_s = mem_s & ~instr_i[20];
    reg_wr_s = (dp_s & (opcode_s[3:2] != 2'b10)) | mem_rd_s | bl_s;
    cpsr_s   = dp_s & instr_i[20];
    shift_s  = dp_s | (mem_s & instr_i[25] & ~instr_i[4]);
    if (br_s) begin
      imm_s = {{(DATA_W-26){instr_i[23]}}, instr_i[23:0], 2'b00};
    end else begin
      imm_s = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};
    end
    use_rn_s = (dp_s & (opcode_s != 4'b1101) & (opcode_s != 4'b1111)) | mem_s;
    use_rm_s = ~(mem_s & ~instr_i[25] & instr_i[20]) & ~bl_s;
    haz_s = instr_valid_i & ex_ld_valid_i &
            ((use_rn_s & (rn_s == ex_ld_rd_i)) | (use_rm_s & (rm_s == ex_ld_rd_i)));
  end

  // Interlock sequencing: next state, counter and what the ID/EX register loads.
  always_comb begin
    load_en_s   = flush_i | ex_ready_i;
    nxt_valid_s = 1'b0;
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    if (flush_i) begin
      nxt_state_s = RUN;
      nxt_cnt_s   = 2'd0;
    end else if (ex_ready_i) begin
      case (state_r)
        RUN: begin
          if (haz_s) begin
            nxt_state_s = INTERLOCK;
            nxt_cnt_s   = 2'(LU_STALL - 1);
          end else begin
            nxt_valid_s = instr_valid_i;
          end
        end
        INTERLOCK: begin
          if (cnt_r != 2'd0) begin
            nxt_cnt_s = cnt_r - 2'd1;
          end else begin
            // Load has left EX by now; the held instruction issues.
            nxt_valid_s = instr_valid_i;
            nxt_state_s = RUN;
          end
        end
        default: begin
          nxt_state_s = RUN;
          nxt_cnt_s   = 2'd0;
        end
      endcase
    end else begin
      nxt_valid_s = 1'b0;
    end
    stall_s = rst_n_i & ~flush_i &
              (~ex_ready_i | ((state_r == RUN) & haz_s) |
               ((state_r == INTERLOCK) & (cnt_r != 2'd0)));
  end

  assign stall_o = stall_s;

  // ID/EX register and interlock state; bubbles clear the control bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= RUN;
      cnt_r         <= 2'd0;
      id_valid_o    <= 1'b0;
      opcode_o      <= 4'd0;
      rn_o          <= '0;
      rd_o          <= '0;
      rm_o          <= '0;
      alu_src_sel_o <= 2'd0;
      reg_wr_en_o   <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      cpsr_en_o     <= 1'b0;
      branch_o      <= 1'b0;
      shifter_en_o  <= 1'b0;
      cond_o        <= 4'd0;
      pc_plus4_o    <= '0;
      imm_o         <= '0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      if (load_en_s) begin
        id_valid_o   <= nxt_valid_s;
        reg_wr_en_o  <= nxt_valid_s & reg_wr_s;
        mem_rd_en_o  <= nxt_valid_s & mem_rd_s;
        mem_wr_en_o  <= nxt_valid_s & mem_wr_s;
        cpsr_en_o    <= nxt_valid_s & cpsr_s;
        branch_o     <= nxt_valid_s & br_s;
        shifter_en_o <= nxt_valid_s & shift_s;
        if (nxt_valid_s) begin
          opcode_o      <= opcode_s;
          rn_o          <= rn_s;
          rd_o          <= rd_s;
          rm_o          <= rm_s;
          alu_src_sel_o <= sel_s;
          cond_o        <= instr_i[31:28];
          pc_plus4_o    <= pc_i + DATA_W'(4);
          imm_o         <= imm_s;
        end
      end
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Saturating counters of stalled cycles and bubbles loaded into ID/EX.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_cnt_o  <= 32'd0;
      perf_bubble_cnt_o <= 32'd0;
    end else begin
      if (stall_s && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (load_en_s && !nxt_valid_s && (perf_bubble_cnt_o != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_decode_stage.sv
// Self-checking bench for arm_decode_stage (LU_STALL = 2): directed
// scenarios plus randomized traffic against a cycle-level reference model.
module tb_arm_decode_stage;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int LU_STALL = 2;

  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic instr_valid_i = 1'b0, flush_i = 1'b0, ex_ready_i = 1'b1, ex_ld_valid_i = 1'b0;
  logic [DATA_W-1:0] pc_i = '0;
  logic [REG_AW-1:0] ex_ld_rd_i = '0;
  logic stall_o, id_valid_o, reg_wr_en_o, mem_rd_en_o, mem_wr_en_o, cpsr_en_o, branch_o, shifter_en_o;
  logic [3:0] opcode_o, cond_o;
  logic [REG_AW-1:0] rn_o, rd_o, rm_o;
  logic [1:0] alu_src_sel_o;
  logic [DATA_W-1:0] pc_plus4_o, imm_o;

  arm_decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LU_STALL(LU_STALL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .pc_i(pc_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_ld_valid_i(ex_ld_valid_i),
    .ex_ld_rd_i(ex_ld_rd_i), .stall_o(stall_o), .id_valid_o(id_valid_o), .opcode_o(opcode_o),
    .rn_o(rn_o), .rd_o(rd_o), .rm_o(rm_o), .alu_src_sel_o(alu_src_sel_o),
    .reg_wr_en_o(reg_wr_en_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .cpsr_en_o(cpsr_en_o), .branch_o(branch_o), .shifter_en_o(shifter_en_o),
    .cond_o(cond_o), .pc_plus4_o(pc_plus4_o), .imm_o(imm_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rn, rd, rm;
    logic [1:0]  sel;
    logic [3:0]  cond;
    logic [31:0] imm;
    logic [5:0]  ctl;   // {reg_wr, mem_rd, mem_wr, cpsr, branch, shifter}
    logic        use_rn, use_rm;
  } dec_t;

  // reference model state
  logic        m_valid;
  logic [5:0]  m_ctl;
  logic [85:0] m_fields;
  int          lu_left;  // stall cycles still owed to the current load-use hazard

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    bit mem, dp, br, bl, ld, imm_i;
    int op;
    mem = (ins[27:26] == 2'd1); dp = (ins[27:26] == 2'd0);
    br = (ins[27:25] == 3'd5);  bl = br && ins[24];
    ld = ins[20]; imm_i = ins[25];
    if (bl) op = 13; else if (mem) op = ins[23] ? 4 : 2; else op = int'(ins[24:21]);
    d.op = 4'(op);
    d.rn = bl ? 4'd0 : ins[19:16];
    d.rd = bl ? 4'd14 : ins[15:12];
    d.rm = ins[3:0];
    d.sel = mem ? 2'd0 : (br ? 2'd1 : 2'd2);
    d.cond = ins[31:28];
    if (br) d.imm = 32'(int'($signed(ins[23:0])) * 4);
    else    d.imm = 32'(int'($signed(ins[11:0])));
    d.ctl = {(dp && !(op >= 8 && op <= 11)) || (mem && ld) || bl,
             mem && ld, mem && !ld, dp && ins[20], br, dp || (mem && imm_i && !ins[4])};
    d.use_rn = (dp && op != 13 && op != 15) || mem;
    d.use_rm = !(mem && !imm_i && ld) && !bl;
    return d;
  endfunction

  function automatic logic ref_haz();
    dec_t d;
    d = ref_decode(instr_i);
    return instr_valid_i && ex_ld_valid_i &&
           ((d.use_rn && d.rn == ex_ld_rd_i) || (d.use_rm && d.rm == ex_ld_rd_i));
  endfunction

  function automatic logic model_stall();
    return !flush_i && (!ex_ready_i || (lu_left == 0 && ref_haz()) || lu_left > 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctl = 6'd0; m_fields = '0; lu_left = 0;
  endtask

  // advance the model with the current inputs, then clock the DUT
  task automatic step();
    dec_t d;
    logic load;
    d = ref_decode(instr_i);
    load = 1'b0;
    if (flush_i) begin
      m_valid = 1'b0; m_ctl = 6'd0; lu_left = 0;
    end else if (ex_ready_i) begin
      if (lu_left > 1) begin
        m_valid = 1'b0; m_ctl = 6'd0; lu_left--;
      end else if (lu_left == 1 || !ref_haz()) begin
        load = 1'b1; lu_left = 0;
      end else begin
        m_valid = 1'b0; m_ctl = 6'd0; lu_left = LU_STALL;
      end
    end
    if (load) begin
      m_valid = instr_valid_i;
      m_ctl = instr_valid_i ? d.ctl : 6'd0;
      if (instr_valid_i) m_fields = {d.op, d.rn, d.rd, d.rm, d.sel, d.cond, 32'(pc_i + 4), d.imm};
    end
    @(posedge clk_i); #1;
  endtask

  function automatic logic [5:0] dut_ctl();
    return {reg_wr_en_o, mem_rd_en_o, mem_wr_en_o, cpsr_en_o, branch_o, shifter_en_o};
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc, input logic iv,
                        input logic rdy, input logic ldv, input logic [3:0] ldrd, input logic fl);
    instr_i = ins; pc_i = pc; instr_valid_i = iv; ex_ready_i = rdy;
    ex_ld_valid_i = ldv; ex_ld_rd_i = ldrd; flush_i = fl;
  endtask

  task automatic test_reset();
    set_in(32'hE0821003, 32'h100, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n_i = 1'b0;
    #12;
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    total++; if (dut_ctl() !== 6'd0) begin bad++; $display("FAIL reset_ctl: got %b want 000000", dut_ctl()); end
    total++; if ({opcode_o, pc_plus4_o, imm_o} !== 68'd0) begin bad++; $display("FAIL reset_fields: got %h want 0", {opcode_o, pc_plus4_o, imm_o}); end
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    set_in(32'hE0821003, 32'h100, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL add_stall: got %b want 0", stall_o); end
    step();
    total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", id_valid_o); end
    total++; if ({opcode_o, rn_o, rd_o, rm_o, alu_src_sel_o} !== {4'b0100, 4'd2, 4'd1, 4'd3, 2'b10})
      begin bad++; $display("FAIL add_fields: got %h want %h", {opcode_o, rn_o, rd_o, rm_o, alu_src_sel_o}, {4'b0100, 4'd2, 4'd1, 4'd3, 2'b10}); end
    total++; if (dut_ctl() !== 6'b100001) begin bad++; $display("FAIL add_ctl: got %b want 100001", dut_ctl()); end
    total++; if (pc_plus4_o !== 32'h104) begin bad++; $display("FAIL add_pc4: got %h want 104", pc_plus4_o); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    set_in(32'hE0821003, 32'h300, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (stall_o === 1'b1) stalls++;
      step();
      ex_ld_valid_i = 1'b0;  // the bubble now sits in EX
      if (c < 2) begin
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL lu_bubble%0d: got %b want 0", c, id_valid_o); end
        total++; if (dut_ctl() !== 6'd0) begin bad++; $display("FAIL lu_bubble_ctl%0d: got %b want 0", c, dut_ctl()); end
      end
    end
    total++; if (stalls != LU_STALL) begin bad++; $display("FAIL lu_stall_cycles: got %0d want %0d", stalls, LU_STALL); end
    total++; if ({id_valid_o, opcode_o, rn_o, pc_plus4_o} !== {1'b1, 4'b0100, 4'd2, 32'h304})
      begin bad++; $display("FAIL lu_issue: got %h want %h", {id_valid_o, opcode_o, rn_o, pc_plus4_o}, {1'b1, 4'b0100, 4'd2, 32'h304}); end
  endtask

  task automatic test_bl();
    set_in(32'hEBFFFFFE, 32'h200, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    total++; if ({rd_o, rn_o, opcode_o, alu_src_sel_o} !== {4'd14, 4'd0, 4'b1101, 2'b01})
      begin bad++; $display("FAIL bl_fields: got %h want %h", {rd_o, rn_o, opcode_o, alu_src_sel_o}, {4'd14, 4'd0, 4'b1101, 2'b01}); end
    total++; if (imm_o !== 32'hFFFFFFF8) begin bad++; $display("FAIL bl_imm: got %h want fffffff8", imm_o); end
    total++; if ({branch_o, reg_wr_en_o, id_valid_o} !== 3'b111) begin bad++; $display("FAIL bl_ctl: got %b want 111", {branch_o, reg_wr_en_o, id_valid_o}); end
  endtask

  task automatic test_backpressure();
    set_in(32'hE5812004, 32'h400, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    set_in(32'hE0821003, 32'h404, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bp_stall%0d: got %b want 1", c, stall_o); end
      step();
      total++; if ({id_valid_o, mem_wr_en_o, opcode_o, imm_o, pc_plus4_o} !== {1'b1, 1'b1, 4'b0100, 32'h4, 32'h404})
        begin bad++; $display("FAIL bp_hold%0d: got %h want %h", c, {id_valid_o, mem_wr_en_o, opcode_o, imm_o, pc_plus4_o}, {1'b1, 1'b1, 4'b0100, 32'h4, 32'h404}); end
    end
    ex_ready_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL bp_release_stall: got %b want 0", stall_o); end
    step();
    total++; if ({mem_wr_en_o, pc_plus4_o} !== {1'b0, 32'h408}) begin bad++; $display("FAIL bp_next: got %h want %h", {mem_wr_en_o, pc_plus4_o}, {1'b0, 32'h408}); end
    set_in(32'hE5012004, 32'h408, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    total++; if ({opcode_o, mem_wr_en_o, mem_rd_en_o} !== {4'b0010, 1'b1, 1'b0}) begin bad++; $display("FAIL str_down: got %h want %h", {opcode_o, mem_wr_en_o, mem_rd_en_o}, {4'b0010, 1'b1, 1'b0}); end
  endtask

  task automatic test_flush_interlock();
    set_in(32'hE0821003, 32'h500, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    step();                      // hazard on rm: now interlocked
    set_in(32'hE0821003, 32'h500, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    set_in(32'hE0821003, 32'h600, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    total++; if ({id_valid_o, dut_ctl()} !== 7'd0) begin bad++; $display("FAIL flush_bubble: got %b want 0", {id_valid_o, dut_ctl()}); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_o); end
    instr_valid_i = 1'b1;
    step();
    total++; if ({id_valid_o, pc_plus4_o} !== {1'b1, 32'h604}) begin bad++; $display("FAIL flush_run: got %h want %h", {id_valid_o, pc_plus4_o}, {1'b1, 32'h604}); end
  endtask

  task automatic test_reset_mid_run();
    set_in(32'hEBFFFFFE, 32'h700, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    set_in(32'hE0821003, 32'h704, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    step();                      // interlocked, stale fields still non-zero
    #2 rst_n_i = 1'b0;
    #1;
    total++; if ({id_valid_o, stall_o, dut_ctl()} !== 8'd0) begin bad++; $display("FAIL midrst_ctl: got %b want 0", {id_valid_o, stall_o, dut_ctl()}); end
    total++; if ({rd_o, opcode_o, pc_plus4_o, imm_o} !== 72'd0) begin bad++; $display("FAIL midrst_fields: got %h want 0", {rd_o, opcode_o, pc_plus4_o, imm_o}); end
    #1 rst_n_i = 1'b1;
    model_reset();
    set_in(32'hE0821003, 32'h800, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    total++; if ({id_valid_o, pc_plus4_o} !== {1'b1, 32'h804}) begin bad++; $display("FAIL midrst_run: got %h want %h", {id_valid_o, pc_plus4_o}, {1'b1, 32'h804}); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[27:25] = 3'b101;
      ins[19:16] = 4'($urandom_range(0, 3));
      ins[3:0]   = 4'($urandom_range(0, 3));
      set_in(ins, {$urandom, 2'b00}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      #1;
      total++; if (stall_o !== model_stall()) begin bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall_o, model_stall()); end
      step();
      total++; if ({id_valid_o, dut_ctl()} !== {m_valid, m_ctl}) begin bad++; $display("FAIL rnd_ctl[%0d]: got %b want %b", n, {id_valid_o, dut_ctl()}, {m_valid, m_ctl}); end
      if (m_valid) begin
        total++;
        if ({opcode_o, rn_o, rd_o, rm_o, alu_src_sel_o, cond_o, pc_plus4_o, imm_o} !== m_fields) begin
          bad++;
          $display("FAIL rnd_fields[%0d]: got %h want %h", n, {opcode_o, rn_o, rd_o, rm_o, alu_src_sel_o, cond_o, pc_plus4_o, imm_o}, m_fields);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_load_use();
    test_bl();
    test_backpressure();
    test_flush_interlock();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
